// File: rtl/cozy_alu_seq_if.sv
// Command channel for cozy_alu_seq: valid/ready handshake carrying either
// a register load or an ALU operation.
interface cozy_alu_seq_if #(
  parameter int ADDR_W = 3
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_load;
  logic [3:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_rd;
  logic [ADDR_W-1:0] cmd_rs;
  logic [15:0]       cmd_data;

  modport master (
    output cmd_valid, cmd_load, cmd_op, cmd_rd, cmd_rs, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_load, cmd_op, cmd_rd, cmd_rs, cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/cozy_alu_seq.sv
// Fetch/execute/writeback sequencer wrapped around the combinational cozy_alu.
// Optional zero flag enabled by defining COZY_ALU_SEQ_ZERO_EN.
module cozy_alu_seq #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  cozy_alu_seq_if.slave     cmd,
  output logic [15:0]       alu_r1,
  output logic [15:0]       alu_r2,
  output logic [3:0]        alu_op,
  output logic              alu_ci,
  input  logic [15:0]       alu_out,
  input  logic              alu_co,
  output logic              carry,
  output logic              done,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [15:0]       dbg_data
`ifdef COZY_ALU_SEQ_ZERO_EN
  ,
  output logic              zero
`endif
);
  localparam int NREG = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;

  state_t state, state_nx;

  logic [NREG-1:0][15:0] rf;
  logic [3:0]            op_q;
  logic [ADDR_W-1:0]     rd_q, rs_q;
  logic [15:0]           res_q;
  logic                  co_q;
  logic                  rdy, ld_acc, op_acc;

  assign cmd.cmd_ready = rdy;
  assign ld_acc = cmd.cmd_valid && rdy &&  cmd.cmd_load;
  assign op_acc = cmd.cmd_valid && rdy && !cmd.cmd_load;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rdy      = 1'b0;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        // Loads complete in IDLE; only ALU ops walk the pipeline.
        if (op_acc) state_nx = FETCH;
      end
      FETCH:   state_nx = EXEC;
      EXEC:    state_nx = WB;
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf       <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      rs_q     <= '0;
      res_q    <= '0;
      co_q     <= 1'b0;
      alu_r1   <= '0;
      alu_r2   <= '0;
      alu_op   <= '0;
      alu_ci   <= 1'b0;
      carry    <= 1'b0;
      done     <= 1'b0;
      dbg_data <= '0;
`ifdef COZY_ALU_SEQ_ZERO_EN
      zero     <= 1'b0;
`endif
    end else begin
      done     <= ld_acc || (state == WB);
      // Sampled before this cycle's write lands: read-before-write.
      dbg_data <= rf[dbg_addr];

      if (ld_acc) rf[cmd.cmd_rd] <= cmd.cmd_data;

      if (op_acc) begin
        op_q <= cmd.cmd_op;
        rd_q <= cmd.cmd_rd;
        rs_q <= cmd.cmd_rs;
      end

      if (state == FETCH) begin
        alu_r1 <= rf[rd_q];
        alu_r2 <= rf[rs_q];
        alu_op <= op_q;
        alu_ci <= carry;
      end

      if (state == EXEC) begin
        res_q <= alu_out;
        co_q  <= alu_co;
      end

      if (state == WB) begin
        rf[rd_q] <= res_q;
        carry    <= co_q;
`ifdef COZY_ALU_SEQ_ZERO_EN
        zero     <= (res_q == 16'h0000);
`endif
      end
    end
  end
endmodule
